// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state type, default sizes and the burst-length helper
// used by the main-memory bus master.
package mem_bus_pkg;

  localparam int DEFAULT_ADDR_W    = 16;
  localparam int DEFAULT_DATA_W    = 16;
  localparam int DEFAULT_MEM_WORDS = 16384;
  localparam int DEFAULT_MAX_BURST = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    RESP
  } state_t;

  // A zero length still moves one word; anything past the burst limit is cut back to it.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_burst);
    if (len == 4'd0) return 4'd1;
    if (int'(len) > max_burst) return 4'(max_burst);
    return len;
  endfunction

endpackage

// File: rtl/mem_burst_counter.sv
// mem_burst_counter: holds the current burst's wrapping issue address and
// counts issued and captured words so the master knows when each side is done.
module mem_burst_counter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [3:0]        start_len,
  input  logic              issue_en,
  input  logic              capture_en,
  output logic [ADDR_W-1:0] issue_next,
  output logic              issue_last,
  output logic              capture_last
);

  logic [ADDR_W-1:0] issue_addr;
  logic [3:0]        len_q;
  logic [3:0]        issue_cnt;
  logic [3:0]        capture_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_addr  <= '0;
      len_q       <= 4'd1;
      issue_cnt   <= '0;
      capture_cnt <= '0;
    end else if (start) begin
      issue_addr  <= start_addr;
      len_q       <= start_len;
      issue_cnt   <= '0;
      capture_cnt <= '0;
    end else begin
      if (issue_en) begin
        issue_addr <= issue_next;
        issue_cnt  <= issue_cnt + 4'd1;
      end
      if (capture_en) capture_cnt <= capture_cnt + 4'd1;
    end
  end

  // The top of the implemented memory wraps back to word 0.
  assign issue_next   = (int'(issue_addr) + 1 >= MEM_WORDS) ? '0 : issue_addr + ADDR_W'(1);
  assign issue_last   = (issue_cnt == len_q - 4'd1);
  assign capture_last = (capture_cnt == len_q - 4'd1);

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator for the main-memory port. Takes single writes and
// 1-8 word burst reads from the sequencer and returns read data as a response stream.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic              capture_pending;
  logic              accept;
  logic              in_range;
  logic              start_read;
  logic              issue_en;
  logic [3:0]        burst_len;
  logic [ADDR_W-1:0] issue_next;
  logic              issue_last;
  logic              capture_last;

  assign accept     = (state == IDLE) && req_valid && req_ready;
  assign in_range   = int'(req_addr) < MEM_WORDS;
  assign start_read = accept && in_range && !req_write;
  assign issue_en   = (state == READ) && !issue_last;
  assign burst_len  = clamp_len(req_len, MAX_BURST);

  mem_burst_counter #(
    .ADDR_W   (ADDR_W),
    .MEM_WORDS(MEM_WORDS)
  ) u_counter (
    .clk         (clk),
    .reset       (reset),
    .start       (start_read),
    .start_addr  (req_addr),
    .start_len   (burst_len),
    .issue_en    (issue_en),
    .capture_en  (capture_pending),
    .issue_next  (issue_next),
    .issue_last  (issue_last),
    .capture_last(capture_last)
  );

  // Memory returns a word the cycle after its address; capture_pending marks
  // that cycle so the word is registered onto the response port one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      req_ready       <= 1'b0;
      busy            <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_last        <= 1'b0;
      rsp_err         <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_we          <= 1'b0;
      capture_pending <= 1'b0;
    end else begin
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_last        <= 1'b0;
      rsp_err         <= 1'b0;
      mem_we          <= 1'b0;
      capture_pending <= (state == READ);
      if (capture_pending) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= mem_rdata;
        rsp_last  <= capture_last;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (!in_range) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_last  <= 1'b1;
            end else if (req_write) begin
              state     <= WRITE;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              mem_we    <= 1'b1;
            end else begin
              state    <= READ;
              mem_addr <= req_addr;
            end
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        READ: begin
          if (issue_last) state <= DRAIN;
          else mem_addr <= issue_next;
        end
        DRAIN: begin
          if (rsp_valid && rsp_last) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        WRITE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_last  <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: drives mem_bus_master against a registered-read memory and
// compares every response window with a transaction-level reference model.
module tb_mem_bus_master;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int WORDS = 16384;
  localparam int WIN   = 12;

  typedef struct packed {
    logic          valid;
    logic          last;
    logic          err;
    logic          we;
    logic          ready;
    logic          busy;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cyc_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_len = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_last;
  logic          rsp_err;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [int];
  logic [DW-1:0] ref_mem [int];
  cyc_t          exp_c [WIN];
  cyc_t          obs_c [WIN];
  bit            chk_addr [WIN];
  int            n_compared = 0;
  int            n_mismatched = 0;

  always #5 clk = ~clk;

  mem_bus_master #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MEM_WORDS(WORDS),
    .MAX_BURST(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_len  (req_len),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_last (rsp_last),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  // Untouched locations hold an address-derived background pattern.
  function automatic logic [DW-1:0] background(input int a);
    return DW'(a * 37 + 'h0505);
  endfunction

  function automatic logic [DW-1:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : background(a);
  endfunction

  // Main memory: one cycle of registered read latency, writes leave read data alone.
  always @(posedge clk) begin
    if (mem_we) mem[int'(mem_addr) % WORDS] = mem_wdata;
    else mem_rdata <= mem.exists(int'(mem_addr) % WORDS) ? mem[int'(mem_addr) % WORDS]
                                                         : background(int'(mem_addr) % WORDS);
  end

  // Reference: the expected per-cycle picture of one request, counted from the accepting edge.
  task automatic model_request(input bit wr, input int addr, input logic [DW-1:0] wd, input int len);
    int n;
    int rdy;
    int a;
    for (int c = 0; c < WIN; c++) begin
      exp_c[c]    = '0;
      chk_addr[c] = 1'b0;
    end
    if (addr >= WORDS) begin
      exp_c[0].valid = 1'b1;
      exp_c[0].err   = 1'b1;
      exp_c[0].last  = 1'b1;
      rdy = 1;
    end else if (wr) begin
      exp_c[0].we    = 1'b1;
      exp_c[0].addr  = AW'(addr);
      exp_c[0].wdata = wd;
      chk_addr[0]    = 1'b1;
      exp_c[1].valid = 1'b1;
      exp_c[1].last  = 1'b1;
      ref_mem[addr]  = wd;
      rdy = 2;
    end else begin
      n = (len == 0) ? 1 : ((len > 8) ? 8 : len);
      for (int k = 0; k < n; k++) begin
        a = (addr + k) % WORDS;
        exp_c[k].addr      = AW'(a);
        chk_addr[k]        = 1'b1;
        exp_c[k+2].valid   = 1'b1;
        exp_c[k+2].rdata   = ref_read(a);
        exp_c[k+2].last    = (k == n - 1);
      end
      rdy = n + 2;
    end
    for (int c = 0; c < WIN; c++) begin
      exp_c[c].ready = (c >= rdy);
      exp_c[c].busy  = (c < rdy);
    end
  endtask

  function automatic cyc_t sample_cycle(input int c);
    cyc_t s;
    s       = '0;
    s.valid = rsp_valid;
    s.we    = mem_we;
    s.ready = req_ready;
    s.busy  = busy;
    if (exp_c[c].valid) begin
      s.last  = rsp_last;
      s.err   = rsp_err;
      s.rdata = rsp_rdata;
    end
    if (chk_addr[c]) s.addr = mem_addr;
    if (exp_c[c].we) s.wdata = mem_wdata;
    return s;
  endfunction

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    n_compared++;
    if (req_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL wait_ready: req_ready got %b want 1 after %0d cycles", req_ready, guard);
    end
  endtask

  task automatic run_request(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input logic [3:0] len);
    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    req_len   = 4'($urandom_range(0, 15));
    for (int c = 0; c < WIN; c++) begin
      if (c > 0) @(negedge clk);
      obs_c[c] = sample_cycle(c);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0004;
    req_wdata = 16'hDEAD;
    repeat (3) @(negedge clk);
    n_compared++;
    if ({req_ready, busy, rsp_valid, rsp_last, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_values: got ready=%b busy=%b valid=%b last=%b err=%b we=%b rdata=%h addr=%h wdata=%h want all 0",
               req_ready, busy, rsp_valid, rsp_last, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata);
    end
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({req_ready, busy, rsp_valid, mem_we} !== 4'b1000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release: got ready=%b busy=%b valid=%b we=%b want 1 0 0 0",
               req_ready, busy, rsp_valid, mem_we);
    end
  endtask

  task automatic test_write_read();
    model_request(1'b1, 'h0010, 16'h1234, 0);
    run_request(1'b1, 16'h0010, 16'h1234, 4'd0);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL write_0010 c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
    model_request(1'b0, 'h0010, '0, 1);
    run_request(1'b0, 16'h0010, '0, 4'd1);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL read_0010 c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_burst_wrap();
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = AW'((16'h3FFE + i) % WORDS);
      model_request(1'b1, int'(a), DW'(16'hA0 + i), 0);
      run_request(1'b1, a, DW'(16'hA0 + i), 4'd0);
      for (int c = 0; c < WIN; c++) begin
        n_compared++;
        if (obs_c[c] !== exp_c[c]) begin
          n_mismatched++;
          $display("[TB] FAIL preload_%0d c%0d: got %h want %h", i, c, obs_c[c], exp_c[c]);
        end
      end
    end
    model_request(1'b0, 'h3FFE, '0, 4);
    run_request(1'b0, 16'h3FFE, '0, 4'd4);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL burst_wrap c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_error();
    model_request(1'b0, 'h4000, '0, 3);
    run_request(1'b0, 16'h4000, '0, 4'd3);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL err_read c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
    model_request(1'b1, 'hFFFF, 16'hBEEF, 0);
    run_request(1'b1, 16'hFFFF, 16'hBEEF, 4'd0);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL err_write c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
    model_request(1'b0, 'h3FFF, '0, 1);
    run_request(1'b0, 16'h3FFF, '0, 4'd1);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL err_unchanged c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_len_clamp();
    model_request(1'b0, 'h0100, '0, 0);
    run_request(1'b0, 16'h0100, '0, 4'd0);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL len0 c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
    model_request(1'b0, 'h0200, '0, 12);
    run_request(1'b0, 16'h0200, '0, 4'd12);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL len12 c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int extra;
    logic [DW-1:0] wd;
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0300;
    req_len   = 4'd8;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({req_ready, busy, rsp_valid, rsp_last, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL midburst_reset: got ready=%b busy=%b valid=%b last=%b err=%b we=%b rdata=%h addr=%h wdata=%h want all 0",
               req_ready, busy, rsp_valid, rsp_last, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
    n_compared++;
    if (req_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midburst_ready: req_ready got %b want 1", req_ready);
    end
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid === 1'b1) extra++;
      @(negedge clk);
    end
    n_compared++;
    if (extra !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL midburst_stray_rsp: got %0d responses want 0", extra);
    end
    wd = DW'($urandom);
    model_request(1'b1, 'h0301, wd, 0);
    run_request(1'b1, 16'h0301, wd, 4'd0);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL post_reset_write c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
    model_request(1'b0, 'h0300, '0, 2);
    run_request(1'b0, 16'h0300, '0, 4'd2);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL post_reset_read c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int we_cycle;
    cyc_t s;
    model_request(1'b0, 'h0020, '0, 4);
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0020;
    req_len   = 4'd4;
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 16'h0021;
    req_wdata = 16'h5A5A;
    req_len   = 4'($urandom_range(0, 15));
    we_cycle  = -1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c <= 6) begin
        s = sample_cycle(c);
        n_compared++;
        if (s !== exp_c[c]) begin
          n_mismatched++;
          $display("[TB] FAIL held_burst c%0d: got %h want %h", c, s, exp_c[c]);
        end
      end
      if (mem_we === 1'b1 && we_cycle < 0) we_cycle = c;
      if (c == 7) req_valid = 1'b0;
    end
    n_compared++;
    if (we_cycle != 7) begin
      n_mismatched++;
      $display("[TB] FAIL held_write_cycle: mem_we first seen cycle %0d want 7", we_cycle);
    end
    model_request(1'b1, 'h0021, 16'h5A5A, 0);
    model_request(1'b0, 'h0020, '0, 2);
    run_request(1'b0, 16'h0020, '0, 4'd2);
    for (int c = 0; c < WIN; c++) begin
      n_compared++;
      if (obs_c[c] !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL held_readback c%0d: got %h want %h", c, obs_c[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_random();
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0]    len;
    for (int i = 0; i < 24; i++) begin
      wr  = ($urandom_range(0, 2) == 0);
      a   = ($urandom_range(0, 5) == 0) ? AW'($urandom_range(WORDS, 65535))
                                        : AW'($urandom_range(0, WORDS - 1));
      wd  = DW'($urandom);
      len = 4'($urandom_range(0, 15));
      model_request(wr, int'(a), wd, int'(len));
      run_request(wr, a, wd, len);
      for (int c = 0; c < WIN; c++) begin
        n_compared++;
        if (obs_c[c] !== exp_c[c]) begin
          n_mismatched++;
          $display("[TB] FAIL random_%0d c%0d: got %h want %h", i, c, obs_c[c], exp_c[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_error();
    test_len_clamp();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Initiator side of the main-memory port: accepts single-word write and 1–8-word burst read requests from the control sequencer, drives the memory's address / write-enable / write-data pins, and returns read data as a response stream. Memory has one cycle of registered read latency (data captured on the edge that samples the address; write cycles do not update read data). Sits between the control FSM (MAR/MBR load path) and the 16Ki×16 main memory.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_WORDS, 16384, implemented memory depth; addresses ≥ MEM_WORDS are out of range
- MAX_BURST, 8, maximum read burst length
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- req_valid  in  1  request present
- req_ready  out  1  block can accept; transfer on req_valid && req_ready at an edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  start address
- req_wdata  in  DATA_W  write data (ignored for reads)
- req_len  in  4  read burst length in words; 0 treated as 1, >MAX_BURST clamped to MAX_BURST; ignored for writes
- rsp_valid  out  1  one-cycle response strobe, no backpressure
- rsp_rdata  out  DATA_W  read word (0 on write ack / error)
- rsp_last  out  1  final response of the request
- rsp_err  out  1  start address out of range
- busy  out  1  request in flight (state ≠ IDLE)
- mem_addr  out  ADDR_W  to memory address pin
- mem_wdata  out  DATA_W  to memory data_in
- mem_we  out  1  to memory write_enable
- mem_rdata  in  DATA_W  from memory data_out

## Operation
- States: IDLE, READ, DRAIN, WRITE, RESP. req_ready = 1 only in IDLE.
- IDLE + accepted read, addr < MEM_WORDS → READ; length N latched, word counter 0.
- READ: one address per cycle, addr_k = (A + k) mod MEM_WORDS (wraps to 0); after N addresses issued → DRAIN; DRAIN lasts until last word captured → IDLE.
- Accepted write, in range → WRITE (mem_we=1, one cycle) → RESP (ack, rsp_rdata=0, rsp_last=1) → IDLE.
- Any accepted request with addr ≥ MEM_WORDS → RESP directly with rsp_err=1, rsp_last=1; no memory access, mem_we stays 0.
- rsp_valid for word k carries mem_rdata registered; rsp_last on word N−1 only.
- mem_we is 1 only during the WRITE cycle; never during reads, error, or reset.
- All outputs registered.

## Timing
- Cycle 0 = cycle following the accepting edge.
- Read: mem_addr = addr_k in cycle k; rsp_valid with word k in cycle k+2; last response cycle N+1; req_ready high cycle N+2. Throughput 1 word/cycle.
- Write: mem_addr/mem_wdata/mem_we in cycle 0; ack in cycle 1; req_ready high cycle 2.
- Error: response in cycle 0; req_ready high cycle 1.
- Reset (reset=0 at an edge): next cycle req_ready=0, busy=0, rsp_valid=0, rsp_rdata=0, rsp_last=0, rsp_err=0, mem_addr=0, mem_wdata=0, mem_we=0; state IDLE. req_ready=1 in first cycle after reset deasserted.
- Reset mid-burst or mid-write: in-flight request abandoned, no further rsp_valid; a write already at cycle 0 edge with reset low is not performed.
- req_valid while not ready: ignored, inputs need not be held by this block.

## Structure
- Package mem_bus_pkg: state enum, ADDR_W/DATA_W/MEM_WORDS/MAX_BURST defaults, burst-length clamp function.
- Sub-module mem_burst_counter: latches start address and length, produces wrapping issue address, issue count and capture count with done flags.

## Test plan
- Write 0x1234 to 0x0010, then read len 1 at 0x0010 → mem_we high exactly cycle 0; read rsp_valid cycle 2 with 0x1234, rsp_last=1, rsp_err=0.
- Preload 0x3FFE..0x0001 with 0xA0..0xA3; burst read addr 0x3FFE len 4 → mem_addr 0x3FFE,0x3FFF,0x0000,0x0001 cycles 0–3; responses 0xA0..0xA3 cycles 2–5, rsp_last only on 0xA3; req_ready high cycle 6.
- Read addr 0x4000 and write addr 0xFFFF → single rsp_valid cycle 0 with rsp_err=1, rsp_last=1, rsp_rdata=0; mem_we never 1; memory unchanged.
- req_len 0 → one word returned; req_len 12 → exactly 8 words.
- Assert reset at cycle 2 of 8-word burst → next cycle all outputs at reset values, no further rsp_valid; new write accepted afterward completes normally.
- req_valid held during a burst → not accepted until req_ready; back-to-back requests each complete with correct data.
